// File: rtl/regb_fifo.sv
// Register-based fall-through FIFO: valid entries are compacted toward stage 0, which drives dout.
// Define REGB_FIFO_ERR_EN to add sticky overflow/underflow flags cleared by err_clr.
module regb_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_in,
  input  logic             shift_out,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             ovf_err,
  output logic             unf_err
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr_idx_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty       = (count_q == {CW{1'b0}});
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign pop_ok_s    = shift_out & ~empty;
  assign push_ok_s   = shift_in & (~full | shift_out);
  // On a simultaneous push/pop the tail slot moves down one stage with the shift.
  assign wr_idx_s    = pop_ok_s ? (count_q - CW'(1)) : count_q;
  assign dout        = stage_q[0];
  assign count       = count_q;

  // Next-state for the storage stages and occupancy count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok_s && (wr_idx_s == CW'(i))) begin
        stage_d[i] = din;
      end else if (pop_ok_s && (i < DEPTH - 1)) begin
        stage_d[i] = stage_q[(i + 1) % DEPTH];
      end else begin
        stage_d[i] = stage_q[i];
      end
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and count registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= {WIDTH{1'b0}};
      end
      count_q <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      count_q <= count_d;
    end
  end

`ifdef REGB_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;
  logic ovf_set_s;
  logic unf_set_s;

  assign ovf_set_s = shift_in & full & ~shift_out;
  assign unf_set_s = shift_out & empty;

  // Sticky error flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_q <= 1'b1;
      end else if (err_clr) begin
        ovf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_q;
      end
      if (unf_set_s) begin
        unf_q <= 1'b1;
      end else if (err_clr) begin
        unf_q <= 1'b0;
      end else begin
        unf_q <= unf_q;
      end
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`else
  logic err_clr_unused;

  assign err_clr_unused = err_clr;
  assign ovf_err        = 1'b0;
  assign unf_err        = 1'b0;
`endif

endmodule

// File: doc/regb_fifo.md
Name: regb_fifo

Overview:
- Parametrised register-based fall-through FIFO of DEPTH data stages, each WIDTH bits.
- Generalises the single-cell shift-register FIFO unit into a complete buffer.
- Adds an occupancy count, full, empty and almost_full flags, and defined simultaneous push/pop behaviour.
- Sits between a producer and a consumer inside one clock domain and is used as the standard small elastic buffer.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of storage stages (>=2).
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- CW, $clog2(DEPTH+1), count width; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- res_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  write data.
- shift_in  input  1  push request.
- shift_out  input  1  pop request.
- err_clr  input  1  clears the sticky error flags (used only with the optional feature).
- dout  output  WIDTH  head-of-FIFO data, i.e. stage 0 register.
- count  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AF_LEVEL.
- ovf_err  output  1  sticky overflow flag.
- unf_err  output  1  sticky underflow flag.

Behaviour:
- Reset (res_n=0, asynchronous):
  - all stages = 0, count = 0, dout = 0, empty = 1, full = 0.
  - almost_full = 0 (AF_LEVEL >= 1), ovf_err = 0, unf_err = 0.
- Storage: stages 0..DEPTH-1. Stage 0 is the head. Valid entries always occupy stages 0..count-1 (compacted toward the head).
- Acceptance:
  - push_ok = shift_in & (~full | shift_out).
  - pop_ok = shift_out & ~empty.
- Per rising edge:
  - pop_ok only: stage[i] <= stage[i+1] for i < DEPTH-1; stage[DEPTH-1] unchanged; count - 1.
  - push_ok only: stage[count] <= din; count + 1.
  - push_ok & pop_ok: shift as for pop, and stage[count-1] <= din; count unchanged.
  - Neither: all stages and count hold.
- Full with push and pop: both accepted; din lands in stage DEPTH-1.
- Empty with push and pop: pop ignored (no bypass), push accepted, count becomes 1, dout = din after the edge.
- Push when full without pop: din dropped, state unchanged.
- Pop when empty: state unchanged.
- Latency: data pushed into an empty FIFO appears on dout one clock after the push edge. dout is valid only while empty = 0.
- When empty, dout shows the last stage-0 content; consumers must not use it.
- Flags are combinational decodes of the registered count, so they are valid in the same cycle count changes. No glitch-free requirement.
- Count arithmetic is CW bits unsigned and never wraps; pointer-free, so there are no wrap-around cases.
- Reset asserted mid-operation clears everything immediately. No partial transfer completes.

Optional Feature:
- Macro: REGB_FIFO_ERR_EN.
- Defined:
  - ovf_err sets on any edge with shift_in & full & ~shift_out.
  - unf_err sets on any edge with shift_out & empty.
  - Both stay set until err_clr = 1 at an edge or reset.
  - If set and clear coincide, set wins.
- Undefined: ovf_err and unf_err are tied to 0, err_clr is ignored, and no error registers are synthesised.
- FIFO data and flag behaviour are identical in both builds.

Test Plan (WIDTH=8, DEPTH=4, AF_LEVEL=3):
- Reset then idle -> dout = 0x00, count = 0, empty = 1, full = 0, almost_full = 0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count goes 1,2,3,4; almost_full = 1 from count = 3; full = 1 at count 4; dout = 0x11 throughout.
- Full, push 0x55 without pop -> count stays 4; four pops then yield 0x11, 0x22, 0x33, 0x44; empty = 1. With REGB_FIFO_ERR_EN, ovf_err = 1 and stays 1 until err_clr is pulsed.
- Full, simultaneous push 0x66 and pop -> dout = 0x22, count = 4; draining yields 0x22, 0x33, 0x44, 0x66.
- Empty, simultaneous push 0x77 and pop -> count = 1, dout = 0x77, unf_err = 1 only if the macro is defined; otherwise unf_err = 0.
- Count = 2, res_n pulsed low between edges -> count = 0, empty = 1, and dout = 0x00 immediately, without waiting for a clock.
